// File: rtl/onehot_decode_pipe.sv
// Two-entry code FIFO feeding a registered one-hot strobe generator.
// Each popped code is driven for HOLD cycles, then a one-cycle gap carries out_done.
module onehot_decode_pipe #(
   parameter int CODE_W = 3,
   parameter int OUT_W  = 8,
   parameter int HOLD   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_en,
   output logic [OUT_W-1:0]  out_onehot,
   output logic              out_valid,
   output logic              out_done,
   output logic              busy
);

   // state | meaning
   // IDLE  | outputs zero; pops the FIFO head when one is waiting
   // DRIVE | one-hot word held on out_onehot while hold_cnt runs down
   // GAP   | all-zero cycle carrying the out_done pulse

   generate
      if (OUT_W != 2**CODE_W) begin : g_bad_out_w
         $error("onehot_decode_pipe: OUT_W must equal 2**CODE_W");
      end
      if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
         $error("onehot_decode_pipe: HOLD must be in 1..255");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

   state_t            state;
   state_t            state_nxt;
   logic [CODE_W:0]   fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic [1:0]        count_nxt;
   logic              push;
   logic              pop;
   logic              head_en;
   logic [CODE_W-1:0] head_code;
   logic [OUT_W-1:0]  head_onehot;
   logic [7:0]        hold_cnt;
   logic [7:0]        hold_nxt;
   logic [OUT_W-1:0]  onehot_nxt;
   logic              valid_nxt;
   logic              done_nxt;

   // Ready looks only at occupancy, so a full FIFO refuses even while popping.
   assign in_ready = rst_n && (count != 2'd2);
   assign push     = in_valid && in_ready;
   assign busy     = (count != 2'd0) || (state != IDLE);

   assign {head_en, head_code} = fifo_mem[rd_ptr];

   always_comb begin
      head_onehot = '0;
      for (int i = 0; i < OUT_W; i++) begin
         if (head_en && (head_code == CODE_W'(i))) begin
            head_onehot[i] = 1'b1;
         end
      end
   end

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count_nxt;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {in_en, in_code};
      end
   end

   always_comb begin
      state_nxt  = state;
      hold_nxt   = hold_cnt;
      onehot_nxt = out_onehot;
      valid_nxt  = out_valid;
      done_nxt   = out_done;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            onehot_nxt = '0;
            valid_nxt  = 1'b0;
            done_nxt   = 1'b0;
            if (count != 2'd0) begin
               pop        = 1'b1;
               onehot_nxt = head_onehot;
               valid_nxt  = 1'b1;
               hold_nxt   = HOLD_M1;
               state_nxt  = DRIVE;
            end
         end
         DRIVE: begin
            if (hold_cnt == 8'd0) begin
               onehot_nxt = '0;
               valid_nxt  = 1'b0;
               done_nxt   = 1'b1;
               state_nxt  = GAP;
            end else begin
               hold_nxt = hold_cnt - 8'd1;
            end
         end
         GAP: begin
            done_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: begin
            onehot_nxt = '0;
            valid_nxt  = 1'b0;
            done_nxt   = 1'b0;
            hold_nxt   = 8'd0;
            state_nxt  = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         hold_cnt   <= 8'd0;
         out_onehot <= '0;
         out_valid  <= 1'b0;
         out_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         out_onehot <= onehot_nxt;
         out_valid  <= valid_nxt;
         out_done   <= done_nxt;
      end
   end

endmodule

// File: tb/tb_onehot_decode_pipe.sv
// Directed bench for onehot_decode_pipe: HOLD=4 instance (a) and HOLD=1 instance (b),
// scoreboard queues filled at each accepted push and drained when a word appears.
module tb_onehot_decode_pipe;

   localparam int HOLD_A = 4;
   localparam int HOLD_B = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid_a, in_ready_a, in_en_a, out_valid_a, out_done_a, busy_a;
   logic [2:0] in_code_a;
   logic [7:0] out_onehot_a;
   logic       in_valid_b, in_ready_b, in_en_b, out_valid_b, out_done_b, busy_b;
   logic [2:0] in_code_b;
   logic [7:0] out_onehot_b;

   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   logic [7:0] exp_a [$];
   logic [7:0] exp_b [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   onehot_decode_pipe #(.CODE_W(3), .OUT_W(8), .HOLD(HOLD_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_code(in_code_a), .in_en(in_en_a), .out_onehot(out_onehot_a),
      .out_valid(out_valid_a), .out_done(out_done_a), .busy(busy_a)
   );

   onehot_decode_pipe #(.CODE_W(3), .OUT_W(8), .HOLD(HOLD_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_code(in_code_b), .in_en(in_en_b), .out_onehot(out_onehot_b),
      .out_valid(out_valid_b), .out_done(out_done_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [2:0] code, input logic en);
      logic acc = 1'b0;
      in_valid_a = 1'b1;
      in_code_a  = code;
      in_en_a    = en;
      for (int i = 0; i < 40 && !acc; i++) begin
         if (in_ready_a) begin
            exp_a.push_back(en ? (8'd1 << code) : 8'd0);
            acc = 1'b1;
         end
         step();
      end
      in_valid_a = 1'b0;
      chk("send_a_accept", 32'(acc), 32'd1);
   endtask

   task automatic send_b(input logic [2:0] code, input logic en);
      logic acc = 1'b0;
      in_valid_b = 1'b1;
      in_code_b  = code;
      in_en_b    = en;
      for (int i = 0; i < 40 && !acc; i++) begin
         if (in_ready_b) begin
            exp_b.push_back(en ? (8'd1 << code) : 8'd0);
            acc = 1'b1;
         end
         step();
      end
      in_valid_b = 1'b0;
      chk("send_b_accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_idle_a(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy_a && !out_valid_a && !out_done_a) break;
         step();
      end
      chk("idle_a_busy", 32'(busy_a), 32'd0);
      chk("idle_a_queue_empty", 32'(exp_a.size()), 32'd0);
   endtask

   task automatic wait_idle_b(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!busy_b && !out_valid_b && !out_done_b) break;
         step();
      end
      chk("idle_b_busy", 32'(busy_b), 32'd0);
      chk("idle_b_queue_empty", 32'(exp_b.size()), 32'd0);
   endtask

   // Monitor for instance a: word order, stability, hold length, done pulse, zero gaps.
   logic [7:0] cur_a;
   int         run_a  = 0;
   logic       prev_a = 1'b0;
   logic       r_a;
   always begin
      @(posedge clk);
      r_a = rst_n;
      #2;
      if (!r_a) begin
         chk("rst_outs_a", 32'({out_valid_a, out_done_a, busy_a, out_onehot_a}), 32'd0);
         run_a  = 0;
         prev_a = 1'b0;
      end else begin
         if (out_valid_a && !prev_a) begin
            chk("word_a_expected", 32'(exp_a.size() != 0), 32'd1);
            cur_a = (exp_a.size() != 0) ? exp_a.pop_front() : 8'hxx;
            chk("word_a", 32'(out_onehot_a), 32'(cur_a));
            run_a = 1;
         end else if (out_valid_a) begin
            run_a++;
            chk("stable_a", 32'(out_onehot_a), 32'(cur_a));
         end else begin
            if (prev_a) begin
               chk("hold_a", 32'(run_a), 32'(HOLD_A));
               chk("done_a", 32'(out_done_a), 32'd1);
            end else begin
               chk("done_idle_a", 32'(out_done_a), 32'd0);
            end
            chk("gap_zero_a", 32'(out_onehot_a), 32'd0);
         end
         prev_a = out_valid_a;
      end
   end

   // Monitor for instance b adds the one-bit and period checks of the back-to-back sweep.
   logic [7:0] cur_b;
   int         run_b     = 0;
   int         words_b   = 0;
   int         last_rise = -1;
   logic       prev_b    = 1'b0;
   logic       r_b;
   always begin
      @(posedge clk);
      r_b = rst_n;
      #2;
      if (!r_b) begin
         chk("rst_outs_b", 32'({out_valid_b, out_done_b, busy_b, out_onehot_b}), 32'd0);
         run_b     = 0;
         prev_b    = 1'b0;
         last_rise = -1;
         words_b   = 0;
      end else begin
         if (out_valid_b && !prev_b) begin
            chk("word_b_expected", 32'(exp_b.size() != 0), 32'd1);
            cur_b = (exp_b.size() != 0) ? exp_b.pop_front() : 8'hxx;
            chk("word_b", 32'(out_onehot_b), 32'(cur_b));
            chk("onebit_b", 32'($countones(out_onehot_b)), 32'd1);
            if (last_rise >= 0) chk("period_b", 32'(cyc - last_rise), 32'(HOLD_B + 2));
            last_rise = cyc;
            words_b++;
            run_b = 1;
         end else if (out_valid_b) begin
            run_b++;
            chk("stable_b", 32'(out_onehot_b), 32'(cur_b));
         end else begin
            if (prev_b) begin
               chk("hold_b", 32'(run_b), 32'(HOLD_B));
               chk("done_b", 32'(out_done_b), 32'd1);
            end else begin
               chk("done_idle_b", 32'(out_done_b), 32'd0);
            end
            chk("gap_zero_b", 32'(out_onehot_b), 32'd0);
         end
         prev_b = out_valid_b;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with in_valid asserted: nothing may be accepted.
      rst_n      = 1'b0;
      in_valid_a = 1'b1; in_code_a = 3'd3; in_en_a = 1'b1;
      in_valid_b = 1'b1; in_code_b = 3'd3; in_en_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_ready_a", 32'(in_ready_a), 32'd0);
         chk("rst_ready_b", 32'(in_ready_b), 32'd0);
      end
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      rst_n      = 1'b1;
      #1;
      chk("post_rst_ready_a", 32'(in_ready_a), 32'd1);
      step();
      step();
      chk("post_rst_busy_a", 32'(busy_a), 32'd0);
      chk("post_rst_valid_a", 32'(out_valid_a), 32'd0);
      chk("post_rst_busy_b", 32'(busy_b), 32'd0);

      // Single code 5: latency and the word itself.
      send_a(3'd5, 1'b1);
      chk("lat_push_valid", 32'(out_valid_a), 32'd0);
      chk("lat_push_busy", 32'(busy_a), 32'd1);
      step();
      chk("lat_first_valid", 32'(out_valid_a), 32'd1);
      chk("lat_first_word", 32'(out_onehot_a), 32'h20);
      wait_idle_a(40);

      // Back-pressure: FIFO fills on the third push; a fourth waits for space.
      send_a(3'd7, 1'b1);
      send_a(3'd0, 1'b1);
      send_a(3'd3, 1'b1);
      chk("full_ready_a", 32'(in_ready_a), 32'd0);
      in_valid_a = 1'b1;
      in_code_a  = 3'd6;
      in_en_a    = 1'b0;
      step();
      chk("full_ready_held_a", 32'(in_ready_a), 32'd0);
      send_a(3'd1, 1'b1);
      wait_idle_a(80);

      // Disabled entry still occupies a full DRIVE with a zero word.
      send_a(3'd6, 1'b0);
      wait_idle_a(40);

      // Reset during the second DRIVE cycle of code 2 with code 4 queued.
      send_a(3'd2, 1'b1);
      send_a(3'd4, 1'b1);
      step();
      chk("mid_drive_valid", 32'(out_valid_a), 32'd1);
      chk("mid_drive_word", 32'(out_onehot_a), 32'h04);
      rst_n = 1'b0;
      exp_a.delete();
      step();
      chk("mid_rst_ready_a", 32'(in_ready_a), 32'd0);
      chk("mid_rst_done_a", 32'(out_done_a), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("discard_busy_a", 32'(busy_a), 32'd0);
      chk("discard_valid_a", 32'(out_valid_a), 32'd0);

      // HOLD=1 instance: sweep all codes back-to-back.
      for (int c = 0; c < 8; c++) send_b(3'(c), 1'b1);
      wait_idle_b(60);
      chk("sweep_words_b", 32'(words_b), 32'd8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
